// File: rtl/sa_feeder.sv
// Tile feeder for the NxN systolic array: captures one A/B tile, then emits the
// diagonally skewed row/column operand streams with a fire strobe and a done pulse.
module sa_feeder #(
  parameter int DW = 8,
  parameter int N  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tile_valid,
  output logic              tile_ready,
  input  logic [N*N*DW-1:0] tile_data,
  input  logic [N*N*DW-1:0] tile_weight,
  input  logic              hold,
  output logic              sa_fire,
  output logic [N*DW-1:0]   sa_data,
  output logic [N*DW-1:0]   sa_weight,
  output logic              busy,
  output logic              done
);

  localparam int TW = $clog2(2*N-1);
  // t names the next step to issue; T_END means every step has gone out.
  localparam logic [TW-1:0] T_END = TW'(2*N-1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]          state;
  logic [TW-1:0]       t;
  logic [N*N*DW-1:0]   a_buf;
  logic [N*N*DW-1:0]   b_buf;
  logic [N*DW-1:0]     step_data;
  logic [N*DW-1:0]     step_weight;
  logic                take;

  assign take = tile_valid && tile_ready;

  // NOTE: the tile buffer has no reset; its contents only matter after a capture.
  always_ff @(posedge clk) begin
    if (take) begin
      a_buf <= tile_data;
      b_buf <= tile_weight;
    end
  end

  // Lane i carries A[i][t-i], lane j carries B[t-j][j]; out-of-range lanes are zero.
  // NOTE: both outputs get a zero default first so no latch is inferred.
  always_comb begin
    step_data   = '0;
    step_weight = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if ((i + k) == int'(t)) begin
          step_data[i*DW +: DW]   = a_buf[(i*N+k)*DW +: DW];
          step_weight[i*DW +: DW] = b_buf[(k*N+i)*DW +: DW];
        end
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= ST_IDLE;
      t          <= '0;
      tile_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      sa_fire    <= 1'b0;
      sa_data    <= '0;
      sa_weight  <= '0;
    end else begin
      done      <= 1'b0;
      sa_fire   <= 1'b0;
      sa_data   <= '0;
      sa_weight <= '0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            state      <= ST_LOAD;
            tile_ready <= 1'b0;
            busy       <= 1'b1;
            t          <= '0;
          end
        end
        ST_LOAD: begin
          // Step 0 is registered on the edge leaving LOAD; hold is not honoured yet.
          sa_fire   <= 1'b1;
          sa_data   <= step_data;
          sa_weight <= step_weight;
          t         <= t + TW'(1);
          state     <= ST_STREAM;
        end
        ST_STREAM: begin
          if (!hold) begin
            if (t == T_END) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              sa_fire   <= 1'b1;
              sa_data   <= step_data;
              sa_weight <= step_weight;
              t         <= t + TW'(1);
            end
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          tile_ready <= 1'b1;
          t          <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_feeder.sv
// Self-checking bench for sa_feeder: directed spec vectors, back-to-back, hold,
// mid-stream reset, ignored tiles, and randomized tiles against a timeline model.
module tb_sa_feeder;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int W  = N*DW;
  localparam int S  = 2*N-1;

  typedef struct packed {
    logic         ready;
    logic         busy;
    logic         done;
    logic         fire;
    logic [W-1:0] data;
    logic [W-1:0] weight;
  } obs_t;

  typedef struct {
    int           step;
    logic [W-1:0] data;
    logic [W-1:0] weight;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic              tile_valid;
  logic              tile_ready;
  logic [N*N*DW-1:0] tile_data;
  logic [N*N*DW-1:0] tile_weight;
  logic              hold;
  logic              sa_fire;
  logic [W-1:0]      sa_data;
  logic [W-1:0]      sa_weight;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  int unsigned cur_a [N][N];
  int unsigned cur_b [N][N];
  int unsigned next_a[N][N];
  int unsigned next_b[N][N];
  bit          hold_at[40];
  int          rst_edge;
  bit          b2b;
  bit          distract;
  logic [W-1:0] rec_d[S];
  logic [W-1:0] rec_w[S];

  sa_feeder #(.DW(DW), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_data(tile_data), .tile_weight(tile_weight), .hold(hold),
    .sa_fire(sa_fire), .sa_data(sa_data), .sa_weight(sa_weight),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.ready  = tile_ready;
    o.busy   = busy;
    o.done   = done;
    o.fire   = sa_fire;
    o.data   = sa_data;
    o.weight = sa_weight;
    return o;
  endfunction

  function automatic logic [N*N*DW-1:0] pack(input int unsigned m[N][N]);
    logic [N*N*DW-1:0] v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        v[(r*N+c)*DW +: DW] = DW'(m[r][c]);
    return v;
  endfunction

  // Reference: step t sends A[i][t-i] on row lane i and B[t-j][j] on column lane j.
  function automatic obs_t step_obs(input int t);
    obs_t o = '0;
    o.busy = 1'b1;
    o.fire = 1'b1;
    for (int i = 0; i < N; i++) begin
      int k = t - i;
      if (k >= 0 && k < N) o.data[i*DW +: DW] = DW'(cur_a[i][k]);
    end
    for (int j = 0; j < N; j++) begin
      int k = t - j;
      if (k >= 0 && k < N) o.weight[j*DW +: DW] = DW'(cur_b[k][j]);
    end
    return o;
  endfunction

  task automatic gen_tile(output int unsigned a[N][N], output int unsigned b[N][N]);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a[r][c] = $urandom_range(255);
        b[r][c] = $urandom_range(255);
      end
  endtask

  task automatic spec_tile();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        cur_a[r][c] = 32'h11 + 32'h10*r + c;
        cur_b[r][c] = 32'h80 + 32'h10*r + c;
      end
  endtask

  task automatic clear_hold();
    for (int e = 0; e < 40; e++) hold_at[e] = 1'b0;
  endtask

  // Presents cur_a/cur_b and follows the tile edge by edge, comparing every cycle
  // with the expected timeline. Entered and left at a falling edge.
  task automatic run_tile(input string tag);
    obs_t exp;
    int   issued = 0;
    int   phase = 0;
    int   guard = 0;
    tile_data   = pack(cur_a);
    tile_weight = pack(cur_b);
    tile_valid  = 1'b1;
    hold        = 1'b0;
    while (!tile_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!tile_ready) begin
      check({tag, "_ready_timeout"}, 128'(tile_ready), 128'(1));
      tile_valid = 1'b0;
      return;
    end
    @(negedge clk);
    exp = '0;
    exp.busy = 1'b1;
    check({tag, "_load"}, 128'(sample()), 128'(exp));
    for (int e = 1; e < 40; e++) begin
      hold  = hold_at[e];
      rst_n = (e == rst_edge);
      if (b2b) begin
        tile_valid  = 1'b1;
        tile_data   = pack(next_a);
        tile_weight = pack(next_b);
      end else if (distract && phase == 0) begin
        tile_valid  = 1'($urandom_range(1));
        tile_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
        tile_weight = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else begin
        tile_valid = 1'b0;
      end
      @(negedge clk);
      exp = '0;
      if (e == rst_edge) begin
        exp.ready = 1'b1;
        phase = 2;
      end else if (phase == 0) begin
        if (issued < S) begin
          if (e >= 2 && hold_at[e]) exp.busy = 1'b1;
          else begin
            exp = step_obs(issued);
            rec_d[issued] = sa_data;
            rec_w[issued] = sa_weight;
            issued++;
          end
        end else if (hold_at[e]) exp.busy = 1'b1;
        else begin
          exp.done = 1'b1;
          phase = 1;
        end
      end else begin
        exp.ready = 1'b1;
        phase = 2;
      end
      check($sformatf("%s_e%0d", tag, e), 128'(sample()), 128'(exp));
      if (phase == 2) break;
    end
    rst_n = 1'b0;
    hold  = 1'b0;
  endtask

  initial begin
    vec_t vecs[3];
    obs_t idle;
    vecs[0] = '{step: 0, data: 32'h00000011, weight: 32'h00000080};
    vecs[1] = '{step: 3, data: 32'h41322314, weight: 32'h8392A1B0};
    vecs[2] = '{step: 6, data: 32'h44000000, weight: 32'hB3000000};
    idle = '0;
    idle.ready = 1'b1;

    rst_n = 1'b1; tile_valid = 1'b0; hold = 1'b0;
    tile_data = '0; tile_weight = '0;
    rst_edge = -1; b2b = 1'b0; distract = 1'b0;
    clear_hold();
    repeat (2) @(negedge clk);
    check("reset_vals", 128'(sample()), 128'(idle));
    rst_n = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 128'(sample()), 128'(idle));

    // Directed tile with the known skew values.
    spec_tile();
    run_tile("spec");
    for (int v = 0; v < 3; v++) begin
      check($sformatf("spec_data_t%0d", vecs[v].step), 128'(rec_d[vecs[v].step]), 128'(vecs[v].data));
      check($sformatf("spec_wgt_t%0d", vecs[v].step), 128'(rec_w[vecs[v].step]), 128'(vecs[v].weight));
    end

    // Reset pulse while idle.
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_reset", 128'(sample()), 128'(idle));
    rst_n = 1'b0;

    // Back-to-back: tile_valid stays high across two distinct tiles.
    gen_tile(cur_a, cur_b);
    gen_tile(next_a, next_b);
    b2b = 1'b1;
    run_tile("b2b_first");
    b2b = 1'b0;
    cur_a = next_a;
    cur_b = next_b;
    run_tile("b2b_second");

    // Two hold cycles where step 3 would go out.
    spec_tile();
    hold_at[4] = 1'b1;
    hold_at[5] = 1'b1;
    run_tile("hold");
    clear_hold();

    // Reset in place of step 4, then a clean tile.
    gen_tile(cur_a, cur_b);
    rst_edge = 5;
    run_tile("rst_mid");
    rst_edge = -1;
    @(negedge clk);
    check("rst_mid_no_done", 128'(sample()), 128'(idle));
    spec_tile();
    run_tile("after_rst");

    // Foreign tiles offered during streaming must be ignored.
    gen_tile(cur_a, cur_b);
    distract = 1'b1;
    run_tile("ignore");
    distract = 1'b0;

    // Randomized tiles, holds and chaining.
    gen_tile(cur_a, cur_b);
    for (int r = 0; r < 25; r++) begin
      clear_hold();
      for (int e = 1; e < 15; e++) hold_at[e] = ($urandom_range(3) == 0);
      b2b = ($urandom_range(2) == 0);
      if (b2b) gen_tile(next_a, next_b);
      distract = !b2b && ($urandom_range(1) == 1);
      run_tile($sformatf("rnd%0d", r));
      if (b2b) begin
        cur_a = next_a;
        cur_b = next_b;
      end else begin
        gen_tile(cur_a, cur_b);
      end
    end
    b2b = 1'b0;
    distract = 1'b0;
    clear_hold();
    run_tile("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_feeder.md
# sa_feeder

Upstream stage of the 4x4 systolic array. Accepts one complete tile of activations and weights through a valid/ready handshake, holds it in a local tile buffer, and emits the diagonally skewed operand streams with a fire strobe that the array's data, weight and fire inputs consume directly. Emitting the skew here keeps the array's edge free of delay lines.

## Interface
- `DW`, 8: operand width in bits.
- `N`, 4: array dimension. Tile is NxN. Skew length is 2N-1.

- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst_n`  in  1  synchronous, active-high reset.
  - Kept under the codebase's reset port name.
  - Asserted means value 1.
- `tile_valid`  in  1  a tile is presented on `tile_data`/`tile_weight`.
- `tile_ready`  out  1  feeder can accept a tile.
- `tile_data`  in  N*N*DW  activations A[i][k]. Byte (i*N+k) at bits [(i*N+k)*DW +: DW].
- `tile_weight`  in  N*N*DW  weights B[k][j]. Byte (k*N+j) at bits [(k*N+j)*DW +: DW].
- `hold`  in  1  stall request; freezes streaming.
- `sa_fire`  out  1  drives the array's fire input.
- `sa_data`  out  N*DW  drives the array's data input. Row lane i at [i*DW +: DW].
- `sa_weight`  out  N*DW  drives the array's weight input. Column lane j at [j*DW +: DW].
- `busy`  out  1  high in LOAD or STREAM.
- `done`  out  1  one-cycle pulse after the last skew step.

## Operation
- Tile buffer: 2·N·N·DW flops. Captured only on a handshake, i.e. `tile_valid && tile_ready` at a clock edge.
- Step counter `t`: 0..2N-2, width ceil(log2(2N-1)).
- FSM states:
  - IDLE: `tile_ready`=1. On handshake, capture the tile and go to LOAD.
  - LOAD: one cycle. Clear `t`, then go to STREAM.
  - STREAM: each unstalled cycle registers the outputs for step `t` and increments `t`. After issuing t=2N-2, go to DONE.
  - DONE: one cycle. `done`=1, then go to IDLE.
- Skew rules for step t:
  - Data lane i = A[i][t-i] if 0 ≤ t-i < N, else 0.
  - Weight lane j = B[t-j][j] if 0 ≤ t-j < N, else 0.
  - `sa_fire`=1.
- Operands pass through unmodified. No arithmetic, no sign handling. Padding lanes are exact zeros.
- `hold` in STREAM:
  - `t` is frozen.
  - The next output cycle has `sa_fire`=0 and `sa_data`=`sa_weight`=0.
  - On release, streaming resumes at the same `t`.
- `hold` outside STREAM is ignored.
- `tile_valid` while not in IDLE is ignored. No capture happens, and the tile buffer is unchanged.
- `tile_ready` is low in LOAD, STREAM and DONE. There is no skid buffer.

## Timing
- Reset values: `tile_ready`=1, `busy`=0, `done`=0, `sa_fire`=0, `sa_data`=0, `sa_weight`=0, state IDLE, `t`=0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- For a handshake at edge C (no hold):
  - Cycle after C: LOAD. `busy`=1, `sa_fire`=0.
  - Cycles C+2 .. C+2N: skew steps t=0..2N-2, with `sa_fire`=1. That is 7 cycles for N=4.
  - Cycle C+2N+1: `done`=1, `busy`=0, `sa_fire`=0, operand outputs 0.
  - Cycle C+2N+2: `tile_ready`=1.
- Tile period with no hold: 2N+2 cycles, i.e. 10 for N=4. Each hold cycle in STREAM adds exactly one cycle.
- `hold` sampled at edge E affects the outputs registered at E.
- Reset mid-operation:
  - Next cycle has all reset values.
  - The partial stream is abandoned. No `done` pulse.
  - The tile buffer contents are don't-care.
- Reset has priority over handshake and `hold` in the same cycle.

## Test plan
- Reset: assert `rst_n`=1 for 2 cycles mid-idle -> all outputs at reset values; `tile_ready`=1.
- Single tile, N=4, with A[i][k]=0x11+0x10·i+k and B[k][j]=0x80+0x10·k+j:
  - t=0 -> `sa_data`=0x00000011, `sa_weight`=0x00000080.
  - t=3 -> `sa_data`=0x41322314, `sa_weight`=0x8392A1B0.
  - t=6 -> `sa_data`=0x44000000, `sa_weight`=0xB3000000.
  - `sa_fire` high exactly 7 cycles; `done` at C+9.
- Back-to-back: `tile_valid` held high with two distinct tiles -> second capture at C+10; no step repeated or lost; `tile_ready` low C+1..C+9.
- Hold: assert `hold` for 2 cycles at t=3 -> two zero/`sa_fire`=0 cycles inserted; t=3 output then resumes unchanged; `done` at C+11.
- Reset at t=4 -> next cycle has outputs zero and `tile_ready`=1; no `done`; the following tile streams correctly from t=0.
- `tile_valid` pulsed with a different tile during STREAM -> ignored; the streamed values match the first tile.
